// File: rtl/seg_chaser_ring.sv
// seg_chaser_ring: multi-segment snake chasing round the frame of two 7-seg banks.
// Optional bounce input/behaviour is enabled by defining SEG_CHASER_BOUNCE_EN.
module seg_chaser_ring #(
    parameter int DIGITS_PER_BANK = 4,
    parameter int TAIL_LEN        = 3,
    parameter int STEP_DIV        = 25000000,
    parameter int SCAN_DIV        = 100000
) (
    input  logic                       clk_trl,
    input  logic                       rst,
    input  logic                       sw,
    input  logic                       pause,
`ifdef SEG_CHASER_BOUNCE_EN
    input  logic                       bounce,
`endif
    output logic [7:0]                 a_to_g_left,
    output logic [7:0]                 a_to_g_right,
    output logic [DIGITS_PER_BANK-1:0] leftseg,
    output logic [DIGITS_PER_BANK-1:0] rightseg,
    output logic                       lap_done
);

    localparam int N        = 2 * DIGITS_PER_BANK;
    localparam int RING_LEN = 2 * N + 4;
    localparam int HW       = $clog2(RING_LEN);
    localparam int DW       = $clog2(N);
    localparam int STW      = $clog2(STEP_DIV + 1);
    localparam int SCW      = $clog2(SCAN_DIV + 1);

    localparam logic [HW-1:0]  HEAD_LAST = HW'(RING_LEN - 1);
    localparam logic [STW-1:0] STEP_LAST = STW'(STEP_DIV - 1);
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]  DIG_LAST  = DW'(N - 1);

    logic [HW-1:0]  head;
    logic [STW-1:0] step_cnt;
    logic [SCW-1:0] scan_cnt;
    logic [DW-1:0]  scan_dig;
    logic           dir;

    logic [7:0]                 seg_next;
    logic [7:0]                 left_bus_next;
    logic [7:0]                 right_bus_next;
    logic [DIGITS_PER_BANK-1:0] left_sel_next;
    logic [DIGITS_PER_BANK-1:0] right_sel_next;

`ifdef SEG_CHASER_BOUNCE_EN
    logic flag;

    // Bounce flag flips on each lap while bounce is held, else stays clear
    always_ff @(posedge clk_trl) begin
        if (rst || !bounce) begin
            flag <= 1'b0;
        end else if (lap_done) begin
            flag <= ~flag;
        end
    end

    assign dir = sw ^ flag;
`else
    assign dir = sw;
`endif

    // Digit that ring position p lands on (frame walked clockwise from top-left)
    function automatic int digit_of(input int p);
        if (p < N) begin
            return p;
        end else if (p <= N + 1) begin
            return N - 1;
        end else if (p <= 2 * N + 1) begin
            return 2 * N + 1 - p;
        end else begin
            return 0;
        end
    endfunction

    // Segment bit that ring position p lights (a=7 ... f=2)
    function automatic logic [7:0] seg_of(input int p);
        if (p < N) begin
            return 8'b1000_0000;
        end else if (p == N) begin
            return 8'b0100_0000;
        end else if (p == N + 1) begin
            return 8'b0010_0000;
        end else if (p <= 2 * N + 1) begin
            return 8'b0001_0000;
        end else if (p == 2 * N + 2) begin
            return 8'b0000_1000;
        end else begin
            return 8'b0000_0100;
        end
    endfunction

    // Head stepping with prescaler and wrap-detect lap pulse
    always_ff @(posedge clk_trl) begin
        if (rst) begin
            head     <= '0;
            step_cnt <= '0;
            lap_done <= 1'b0;
        end else begin
            lap_done <= 1'b0;
            if (!pause) begin
                if (step_cnt == STEP_LAST) begin
                    step_cnt <= '0;
                    if (!dir) begin
                        head     <= (head == HEAD_LAST) ? '0 : head + HW'(1);
                        lap_done <= (head == HEAD_LAST);
                    end else begin
                        head     <= (head == '0) ? HEAD_LAST : head - HW'(1);
                        lap_done <= (head == '0);
                    end
                end else begin
                    step_cnt <= step_cnt + STW'(1);
                end
            end
        end
    end

    // Free-running digit scan, never paused
    always_ff @(posedge clk_trl) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_dig <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_dig <= (scan_dig == DIG_LAST) ? '0 : scan_dig + DW'(1);
        end else begin
            scan_cnt <= scan_cnt + SCW'(1);
        end
    end

    // Segments of the scanned digit: a position is lit when it trails the head by < TAIL_LEN
    always_comb begin
        int d;
        d        = 0;
        seg_next = '0;
        for (int p = 0; p < RING_LEN; p++) begin
            d = dir ? p - int'(head) : int'(head) - p;
            if (d < 0) begin
                d = d + RING_LEN;
            end
            if (d < TAIL_LEN && digit_of(p) == int'(scan_dig)) begin
                seg_next = seg_next | seg_of(p);
            end
        end
    end

    // Route the scanned digit to its bank; the idle bank stays dark
    always_comb begin
        left_bus_next  = '0;
        right_bus_next = '0;
        left_sel_next  = '0;
        right_sel_next = '0;
        if (int'(scan_dig) < DIGITS_PER_BANK) begin
            left_bus_next = seg_next;
        end else begin
            right_bus_next = seg_next;
        end
        for (int i = 0; i < DIGITS_PER_BANK; i++) begin
            if (int'(scan_dig) == DIGITS_PER_BANK - 1 - i) begin
                left_sel_next[i] = 1'b1;
            end
            if (int'(scan_dig) == N - 1 - i) begin
                right_sel_next[i] = 1'b1;
            end
        end
    end

    // Registered display outputs
    always_ff @(posedge clk_trl) begin
        if (rst) begin
            a_to_g_left  <= '0;
            a_to_g_right <= '0;
            leftseg      <= '0;
            rightseg     <= '0;
        end else begin
            a_to_g_left  <= left_bus_next;
            a_to_g_right <= right_bus_next;
            leftseg      <= left_sel_next;
            rightseg     <= right_sel_next;
        end
    end

endmodule

// File: tb/tb_seg_chaser_ring.sv
// Self-checking bench for seg_chaser_ring against a position-list reference model.
// Bounce stimulus is included when SEG_CHASER_BOUNCE_EN is defined.
module tb_seg_chaser_ring;

    localparam int DPB = 4;
    localparam int N   = 2 * DPB;
    localparam int R   = 2 * N + 4;
    localparam int TL  = 3;
    localparam int SD  = 4;
    localparam int CD  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw = 1'b0;
    logic       pause = 1'b0;
    logic       bounce = 1'b0;
    logic [7:0] al;
    logic [7:0] ar;
    logic [3:0] ls;
    logic [3:0] rs;
    logic       lap;

    int n_assert = 0;
    int n_fail = 0;
    int lap_seen = 0;

    int m_head = 0;
    int m_step = 0;
    int m_scan = 0;
    int m_dig = 0;
    int m_flag = 0;
    int m_lap = 0;
    int m_out_dig = -1;

    always #5 clk = ~clk;

    seg_chaser_ring #(
        .DIGITS_PER_BANK(DPB),
        .TAIL_LEN(TL),
        .STEP_DIV(SD),
        .SCAN_DIV(CD)
    ) dut (
        .clk_trl(clk),
        .rst(rst),
        .sw(sw),
        .pause(pause),
`ifdef SEG_CHASER_BOUNCE_EN
        .bounce(bounce),
`endif
        .a_to_g_left(al),
        .a_to_g_right(ar),
        .leftseg(ls),
        .rightseg(rs),
        .lap_done(lap)
    );

    function automatic int digit_of(input int p);
        if (p < N) return p;
        if (p == N || p == N + 1) return N - 1;
        if (p <= 2 * N + 1) return 2 * N + 1 - p;
        return 0;
    endfunction

    function automatic logic [7:0] seg_of(input int p);
        if (p < N) return 8'h80;
        if (p == N) return 8'h40;
        if (p == N + 1) return 8'h20;
        if (p <= 2 * N + 1) return 8'h10;
        if (p == 2 * N + 2) return 8'h08;
        return 8'h04;
    endfunction

    // Expected {left bus, right bus, left sel, right sel, lap} from the model state
    function automatic logic [24:0] predict();
        logic [7:0] segs;
        logic [3:0] one;
        int         dir;
        int         pos;
        segs = 8'h00;
        one  = 4'b1000;
        dir  = int'(sw) ^ m_flag;
        for (int k = 0; k < TL; k++) begin
            pos = dir ? (m_head + k) % R : (m_head - k + R) % R;
            if (digit_of(pos) == m_dig) segs = segs | seg_of(pos);
        end
        if (m_dig < DPB) return {segs, 8'h00, one >> m_dig, 4'b0000, 1'b0};
        return {8'h00, segs, 4'b0000, one >> (m_dig - DPB), 1'b0};
    endfunction

    task automatic check(input string tag, input logic [24:0] got, input logic [24:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic timeout(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s timeout observed=none expected=event", tag);
    endtask

    task automatic tick();
        logic [24:0] want;
        int          dir;
        int          new_lap;
        want = predict();
        @(posedge clk);
        if (rst) begin
            m_head = 0; m_step = 0; m_scan = 0; m_dig = 0;
            m_flag = 0; m_lap = 0; m_out_dig = -1;
            want = '0;
        end else begin
            m_out_dig = m_dig;
            dir = int'(sw) ^ m_flag;
            new_lap = 0;
            if (!pause) begin
                if (m_step == SD - 1) begin
                    m_step = 0;
                    if (dir == 0) begin
                        if (m_head == R - 1) new_lap = 1;
                        m_head = (m_head + 1) % R;
                    end else begin
                        if (m_head == 0) new_lap = 1;
                        m_head = (m_head + R - 1) % R;
                    end
                end else begin
                    m_step++;
                end
            end
            if (!bounce) m_flag = 0;
            else if (m_lap != 0) m_flag = 1 - m_flag;
            m_lap = new_lap;
            if (m_scan == CD - 1) begin
                m_scan = 0;
                m_dig = (m_dig + 1) % N;
            end else begin
                m_scan++;
            end
            want[0] = (m_lap != 0);
        end
        #1;
        lap_seen += int'(lap);
        check("outputs", {al, ar, ls, rs, lap}, want);
    endtask

    task automatic run_to(input int h);
        int ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (m_head == h) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) timeout("run_to");
    endtask

    task automatic show(input string tag, input int dg, input logic [7:0] el,
                        input logic [7:0] er, input logic [3:0] els, input logic [3:0] ers);
        int ok;
        ok = 0;
        for (int i = 0; i < 2 * N + 2; i++) begin
            tick();
            if (m_out_dig == dg) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) timeout(tag);
        else check(tag, {1'b0, al, ar, ls, rs}, {1'b0, el, er, els, ers});
    endtask

    initial begin
        tick();
        tick();
        check("reset_state", {1'b0, al, ar, ls, rs}, 25'd0);
        rst = 1'b0;
        tick();
        check("release_dig0", {1'b0, al, ar, ls, rs}, {1'b0, 8'b1000_1100, 8'h00, 4'b1000, 4'b0000});

        run_to(5);
        pause = 1'b1;
        show("h5_dig3", 3, 8'h80, 8'h00, 4'b0001, 4'b0000);
        show("h5_dig4", 4, 8'h00, 8'h80, 4'b0000, 4'b1000);
        show("h5_dig5", 5, 8'h00, 8'h80, 4'b0000, 4'b0100);
        show("h5_dig6", 6, 8'h00, 8'h00, 4'b0000, 4'b0010);
        pause = 1'b0;

        lap_seen = 0;
        run_to(0);
        tick();
        tick();
        check("lap_single", 25'(lap_seen), 25'd1);
        pause = 1'b1;
        show("h0_dig0", 0, 8'b1000_1100, 8'h00, 4'b1000, 4'b0000);
        pause = 1'b0;

        run_to(9);
        pause = 1'b1;
        sw = 1'b1;
        show("rev_tail", 7, 8'h00, 8'b0011_0000, 4'b0000, 4'b0001);
        pause = 1'b0;
        run_to(8);
        pause = 1'b1;
        show("rev_h8", 7, 8'h00, 8'b0111_0000, 4'b0000, 4'b0001);
        for (int i = 0; i < 50; i++) tick();
        check("pause_hold", 25'(m_head), 25'd8);
        pause = 1'b0;

        run_to(13);
        rst = 1'b1;
        sw = 1'b0;
        tick();
        check("midrun_rst", {1'b0, al, ar, ls, rs}, 25'd0);
        rst = 1'b0;
        tick();
        check("rerelease_dig0", {1'b0, al, ar, ls, rs}, {1'b0, 8'b1000_1100, 8'h00, 4'b1000, 4'b0000});

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) sw = ~sw;
            pause = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
`ifdef SEG_CHASER_BOUNCE_EN
            if ($urandom_range(0, 63) == 0) bounce = ~bounce;
`endif
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
